// File: rtl/l2c_cout_fifo.sv
// Response buffer behind the L2C output arbiter: DEPTH-entry circular FIFO, req/ack toward the core.
// Latency 1 cycle when empty (0 with L2C_COUT_BYPASS_EN); no input backpressure, afull warns, ovf flags drops.
`ifndef CORE_UID_W
`define CORE_UID_W 8
`endif
`ifndef CORE_DATA_W
`define CORE_DATA_W 32
`endif

module l2c_cout_fifo #(
  parameter int DEPTH     = 4,
  parameter int UID_W     = `CORE_UID_W,
  parameter int DATA_W    = `CORE_DATA_W,
  parameter int AFULL_MRG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_rdy,
  input  logic [UID_W-1:0]           in_uid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       afull,
  output logic                       out_req,
  output logic [UID_W-1:0]           out_uid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ack,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_MRG);

  logic [UID_W-1:0]  mem_uid_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              count_nz, full, pop, rd_adv, push;
  logic [CW-1:0]     free_cnt;

  always_comb begin
    count_nz = (count_q != '0);
    full     = (count_q == DEPTH_C);
    out_req  = count_nz;
    out_uid  = count_nz ? mem_uid_q[rd_ptr_q]  : '0;
    out_data = count_nz ? mem_data_q[rd_ptr_q] : '0;
`ifdef L2C_COUT_BYPASS_EN
    if (!count_nz && in_rdy) begin
      out_req  = 1'b1;
      out_uid  = in_uid;
      out_data = in_data;
    end
`endif
    pop    = out_req && out_ack;
    rd_adv = pop && count_nz;
    // A bypassed beat that is acked in the same cycle never touches the memory.
    push   = in_rdy && (!full || pop) && !(pop && !count_nz);
  end

  always_comb begin
    wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(rd_adv);
    ovf_d    = ovf_q || (in_rdy && full && !pop);
  end

  always_comb begin
    free_cnt = DEPTH_C - count_q;
    afull    = (free_cnt <= AFULL_C);
    ovf      = ovf_q;
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; out_* are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_uid_q[wr_ptr_q]  <= in_uid;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_l2c_cout_fifo.sv
// Randomized and directed bench for l2c_cout_fifo against a queue-based reference model.
module tb_l2c_cout_fifo;
  localparam int DEPTH = 4;
  localparam int MRG   = 1;
`ifdef L2C_COUT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rdy;
  logic [7:0]  in_uid;
  logic [31:0] in_data;
  logic        afull;
  logic        out_req;
  logic [7:0]  out_uid;
  logic [31:0] out_data;
  logic        out_ack;
  logic        ovf;
  logic [2:0]  count;

  l2c_cout_fifo #(.DEPTH(DEPTH), .UID_W(8), .DATA_W(32), .AFULL_MRG(MRG)) dut (
    .clk(clk), .rst(rst), .in_rdy(in_rdy), .in_uid(in_uid), .in_data(in_data),
    .afull(afull), .out_req(out_req), .out_uid(out_uid), .out_data(out_data),
    .out_ack(out_ack), .ovf(ovf), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  uid;
    logic [31:0] data;
  } beat_t;

  beat_t mq[$];
  bit    m_ovf;
  int    tests = 0;
  int    fails = 0;
  bit    chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: state advances on every clock edge from the sampled inputs.
  int m_sz;
  bit m_byp, m_req, m_pop;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_byp = BYP && (m_sz == 0) && in_rdy;
      m_req = (m_sz != 0) || m_byp;
      m_pop = m_req && out_ack;
      if (!(m_byp && out_ack)) begin
        if (m_pop) void'(mq.pop_front());
        if (in_rdy) begin
          if (m_sz < DEPTH || m_pop) mq.push_back('{uid: in_uid, data: in_data});
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Compare process: outputs after inputs settle, well before the next edge.
  bit          e_req;
  logic [7:0]  e_uid;
  logic [31:0] e_data;
  always @(negedge clk) begin
    #1;
    if (chk_en && !rst) begin
      e_req  = (mq.size() != 0) || (BYP && in_rdy);
      e_uid  = '0;
      e_data = '0;
      if (mq.size() != 0) begin
        e_uid  = mq[0].uid;
        e_data = mq[0].data;
      end else if (BYP && in_rdy) begin
        e_uid  = in_uid;
        e_data = in_data;
      end
      chk("m_out_req", 64'(out_req), 64'(e_req));
      chk("m_out_uid", 64'(out_uid), 64'(e_uid));
      chk("m_out_data", 64'(out_data), 64'(e_data));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_afull", 64'(afull), 64'((DEPTH - mq.size()) <= MRG));
      chk("m_ovf", 64'(ovf), 64'(m_ovf));
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] u, input logic [31:0] d, input bit a);
    @(negedge clk);
    rst = r; in_rdy = v; in_uid = u; in_data = d; out_ack = a;
    #2;
  endtask

  task automatic drain;
    int n = 0;
    while (count != 0 && n < 20) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    step(0, 0, 0, 0, 0);
    chk("drain_empty", 64'(count), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_rdy = 1'b0; in_uid = '0; in_data = '0; out_ack = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 8'h77, 32'h1, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_req", 64'(out_req), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_afull", 64'(afull), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_uid", 64'(out_uid), 64'(0));
    chk_en = 1'b1;

    // Single beat, held while not acked.
    step(0, 1, 8'd3, 32'hCAFE0001, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("t1_req", 64'(out_req), 64'(1));
      chk("t1_uid", 64'(out_uid), 64'(3));
      chk("t1_data", 64'(out_data), 64'(32'hCAFE0001));
      chk("t1_count", 64'(count), 64'(1));
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t1_count_after_ack", 64'(count), 64'(0));
    chk("t1_req_after_ack", 64'(out_req), 64'(0));

    // Fill, overflow, drain in order.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'(i), 32'h100 + 32'(i), 0);
      chk("t2_count", 64'(count), 64'(i));
      chk("t2_afull", 64'(afull), 64'(i >= 3));
    end
    step(0, 0, 0, 0, 0);
    chk("t2_full_count", 64'(count), 64'(4));
    chk("t2_ovf", 64'(ovf), 64'(1));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      chk("t2_order", 64'(out_uid), 64'(i));
    end
    step(0, 0, 0, 0, 0);
    chk("t2_empty", 64'(count), 64'(0));

    // Reset with queued beats and in_rdy high.
    for (int i = 0; i < 3; i++) step(0, 1, 8'(50 + i), 32'(i), 0);
    step(1, 1, 8'hEE, 32'hEE, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_req", 64'(out_req), 64'(0));
    chk("t5_count", 64'(count), 64'(0));
    chk("t5_ovf", 64'(ovf), 64'(0));
    chk("t5_afull", 64'(afull), 64'(0));

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(0, 1, 8'(10 + i), 32'(i), 0);
    step(0, 1, 8'd9, 32'h9, 1);
    chk("t3_head", 64'(out_uid), 64'(10));
    step(0, 0, 0, 0, 0);
    chk("t3_count", 64'(count), 64'(4));
    chk("t3_ovf", 64'(ovf), 64'(0));
    chk("t3_next", 64'(out_uid), 64'(11));
    for (int i = 0; i < 10; i++) step(0, 1, 8'(20 + i), 32'(i), 1);
    step(0, 0, 0, 0, 0);
    chk("t3_wrap_count", 64'(count), 64'(4));
    chk("t3_wrap_head", 64'(out_uid), 64'(26));
    drain();

    // Streaming: one beat per cycle, occupancy 1.
    step(0, 1, 8'd40, 32'h40, 0);
    for (int i = 1; i < 9; i++) begin
      step(0, 1, 8'(40 + i), 32'h40 + 32'(i), 1);
      chk("t4_count", 64'(count), 64'(1));
      chk("t4_uid", 64'(out_uid), 64'(40 + i - 1));
    end
    drain();
    chk("t4_ovf", 64'(ovf), 64'(0));

    // Push into empty FIFO with same-cycle ack.
    step(0, 1, 8'd5, 32'h5, 1);
    chk("t6_req_same", 64'(out_req), 64'(BYP));
    step(0, 0, 0, 0, 0);
    chk("t6_count_next", 64'(count), 64'(BYP ? 0 : 1));
    chk("t6_req_next", 64'(out_req), 64'(BYP ? 0 : 1));
    drain();

    // Randomized phases with varying push/ack rates and rare resets.
    for (int ph = 0; ph < 6; ph++) begin
      int pv = 20 + ph * 15;
      int pa = 90 - ph * 15;
      for (int c = 0; c < 400; c++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < pv),
             8'($urandom), 32'($urandom),
             ($urandom_range(0, 99) < pa));
      end
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
